// File: rtl/timetag_pkg.sv
// Shared types and constants for the fx2_clk-side sample framing logic.
package timetag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BYTES
  } state_t;

  localparam logic [3:0]  HDR_MARKER = 4'hA;
  localparam int unsigned COUNT_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together
// yield 1 so a coincident event is not lost.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sample_framer.sv
// Pops samples from a show-ahead FIFO and serialises each into bytes for the
// FX2 interface, with optional sequence-number header and a record tally.
module sample_framer
  import timetag_pkg::*;
#(
  parameter int unsigned SAMPLE_BYTES = 6,
  parameter bit          HEADER_EN    = 1'b0,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sample_rdy,
  input  logic [8*SAMPLE_BYTES-1:0] sample,
  output logic                      sample_ack,
  output logic                      data_rdy,
  output logic [7:0]                data,
  input  logic                      data_ack,
  input  logic                      count_clr,
  output logic [COUNT_W-1:0]        record_count,
  output logic                      busy
);

  localparam int unsigned SW    = 8 * SAMPLE_BYTES;
  localparam int unsigned IDX_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_BYTES - 1);

  state_t           state_q, state_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       seq_q, seq_d;
  logic             ack_c;
  logic             rec_done;
  logic [7:0]       data_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
    end
  end

  // The outgoing byte is always at one end of the shift register; the
  // register shifts toward that end on each transferred payload byte.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    ack_c    = 1'b0;
    rec_done = 1'b0;
    data_c   = '0;
    unique case (state_q)
      IDLE: begin
        if (sample_rdy) begin
          ack_c   = 1'b1;
          sr_d    = sample;
          idx_d   = '0;
          state_d = HEADER_EN ? HDR : BYTES;
        end
      end
      HDR: begin
        data_c = {HDR_MARKER, seq_q};
        if (data_ack) begin
          state_d = BYTES;
        end
      end
      BYTES: begin
        data_c = MSB_FIRST ? sr_q[SW-1 -: 8] : sr_q[7:0];
        if (data_ack) begin
          sr_d  = MSB_FIRST ? (sr_q << 8) : (sr_q >> 8);
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            rec_done = 1'b1;
            seq_d    = seq_q + 4'd1;
            // Chain straight into the next record when the FIFO has one.
            if (sample_rdy) begin
              ack_c   = 1'b1;
              sr_d    = sample;
              idx_d   = '0;
              state_d = HEADER_EN ? HDR : BYTES;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_rdy   = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign data       = data_c;
  // Pop strobe is combinational; gate it so it is low while reset is held.
  assign sample_ack = ack_c & reset_n;

  sat_counter #(
    .WIDTH(COUNT_W)
  ) u_record_count (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (count_clr),
    .inc    (rec_done),
    .count  (record_count)
  );

endmodule
